inst_queue: RTL and testbench

- Small instruction buffer directly downstream of the IF/ID register. Sits between fetch and decode.
- Accepts {pc, inst} pairs from fetch using a valid/ready handshake and presents them in order to decode.
- Decouples AXI fetch latency from decode stalls.
- A branch/jump redirect (pc_b_j) flushes all buffered entries.

---
 rtl/inst_queue_pkg.sv | 16 +
 rtl/inst_queue_mem.sv | 27 ++
 rtl/inst_queue.sv | 96 +++++++++
 tb/tb_inst_queue.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// Consumers of inst_queue import this package for the entry layout and reset constants.
package inst_queue_pkg;

    localparam int PKG_PC_W   = 32;
    localparam int PKG_INST_W = 32;

    localparam logic [PKG_INST_W-1:0] INST_NOP = 32'h0000_0013;
    localparam logic [PKG_PC_W-1:0]   PC_RESET = 32'h8000_0000;

    typedef struct packed {
        logic [PKG_PC_W-1:0]   pc;
        logic [PKG_INST_W-1:0] inst;
    } inst_entry_t;

endpackage

// File: rtl/inst_queue_mem.sv
// Entry storage for inst_queue: DEPTH x WIDTH register array,
// synchronous write port and asynchronous read port.
module inst_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage is deliberately not reset; validity is tracked by the pointers alone.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_queue.sv
// In-order instruction buffer between IF/ID and decode; flush discards all entries.
// Define INST_QUEUE_BYPASS_EN for a zero-latency empty-queue path from fetch to decode.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int PTR_W   = ADDR_W + 1;
    localparam int ENTRY_W = PC_W + INST_W;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               empty, full;
    logic               push, pop;
    logic               mem_we, mem_pop;
    logic [ENTRY_W-1:0] head_entry;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign count = wr_ptr_q - rd_ptr_q;

    // in_ready never looks at out_ready, so a slot freed by a pop opens one cycle later.
    assign in_ready = ~full & ~flush;
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign mem_pop  = pop & ~empty;

`ifdef INST_QUEUE_BYPASS_EN
    logic bypass;

    assign bypass    = empty & in_valid & ~flush;
    assign out_valid = (~empty & ~flush) | bypass;
    assign out_pc    = empty ? (bypass ? in_pc   : '0) : head_entry[ENTRY_W-1:INST_W];
    assign out_inst  = empty ? (bypass ? in_inst : '0) : head_entry[INST_W-1:0];
    // An entry consumed straight through the bypass is never stored.
    assign mem_we    = push & ~(bypass & out_ready);
`else
    assign out_valid = ~empty & ~flush;
    assign out_pc    = empty ? '0 : head_entry[ENTRY_W-1:INST_W];
    assign out_inst  = empty ? '0 : head_entry[INST_W-1:0];
    assign mem_we    = push;
`endif

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (mem_we)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (mem_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    inst_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata ({in_pc, in_inst}),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (head_entry)
    );

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: a reference occupancy model plus an in-order
// scoreboard of pushed entries, compared against the DUT every cycle.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;
    inst_entry_t sb[$];

    inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input logic r, input logic f, input logic iv, input logic orr,
                        input logic [31:0] pc);
        logic [31:0] inst;
        logic [31:0] exp_pc, exp_inst;
        bit          empty, exp_ir, exp_ov, byp;
        inst_entry_t head;

        inst      = {pc[15:0], 16'h0013};
        rst       = r;
        flush     = f;
        in_valid  = iv;
        out_ready = orr;
        in_pc     = pc;
        in_inst   = inst;
        #4;

        empty  = (sb.size() == 0);
        exp_ir = (sb.size() < DEPTH) && !f;
        byp    = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
        byp    = empty && iv && !f;
`endif
        exp_ov = (!empty && !f) || byp;
        if (!empty) begin
            exp_pc   = sb[0].pc;
            exp_inst = sb[0].inst;
        end else if (byp) begin
            exp_pc   = pc;
            exp_inst = inst;
        end else begin
            exp_pc   = '0;
            exp_inst = '0;
        end

        check("in_ready",  64'(in_ready),  64'(exp_ir));
        check("out_valid", 64'(out_valid), 64'(exp_ov));
        check("count",     64'(count),     64'(sb.size()));
        check("out_pc",    64'(out_pc),    64'(exp_pc));
        check("out_inst",  64'(out_inst),  64'(exp_inst));

        if (r || f) begin
            sb.delete();
        end else begin
            if (exp_ov && orr && !empty) begin
                head = sb.pop_front();
                check("pop_pc",   64'(out_pc),   64'(head.pc));
                check("pop_inst", 64'(out_inst), 64'(head.inst));
            end
            if (iv && exp_ir && !(byp && orr)) begin
                sb.push_back('{pc: pc, inst: inst});
            end
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);

        // Reset then idle
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 1, 32'h0);

        // Fill with decode stalled, refuse a fifth push, then drain in order
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, PC_RESET + 32'(4 * i));
        step(0, 0, 1, 0, PC_RESET + 32'h10);
        step(0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 32'h0);

        // Concurrent streaming across several pointer wraps
        for (int i = 0; i < 20; i++) step(0, 0, 1, 1, PC_RESET + 32'h20 + 32'(4 * i));
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 32'h0);

        // Flush mid-stream with fetch still offering
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, PC_RESET + 32'h80 + 32'(4 * i));
        step(0, 1, 1, 1, PC_RESET + 32'h8C);
        step(0, 0, 1, 0, PC_RESET + 32'h100);
        step(0, 0, 0, 1, 32'h0);
        step(0, 0, 0, 1, 32'h0);

        // Flush held several cycles, including on an empty queue
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, PC_RESET + 32'h200);
        step(0, 0, 0, 0, 32'h0);

        // Full with pop: in_ready stays low in the pop cycle, rises the next
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, PC_RESET + 32'h300 + 32'(4 * i));
        step(0, 0, 1, 1, PC_RESET + 32'h310);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 1, 0, PC_RESET + 32'h314);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 32'h0);

        // Reset wins over flush, push and pop
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0, PC_RESET + 32'h400 + 32'(4 * i));
        step(1, 1, 1, 1, PC_RESET + 32'h408);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
